// File: rtl/uart_program_loader.sv
// Boot loader: receives a program over 8N1 UART, assembles little-endian words,
// writes them into instruction memory and holds the core in reset until done.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORD_COUNT   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic        load_req,
    output logic        imem_we,
    output logic [4:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        frame_err,
    output logic [5:0]  words_loaded
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_COUNT, L_DATA, L_DONE} ld_state_t;

    logic             rx_meta_r, rx_sync_r;
    rx_state_t        rx_state_r, rx_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r, rx_byte_r;
    logic             byte_valid_r;
    logic             half_hit_s, full_hit_s, stop_sample_s, frame_set_s;

    ld_state_t        ld_state_r, ld_next_s;
    logic [5:0]       n_r, words_loaded_r;
    logic [1:0]       byte_idx_r;
    logic [4:0]       word_idx_r, imem_addr_r;
    logic [31:0]      word_r, imem_wdata_r;
    logic             imem_we_r, core_reset_r, load_done_r, frame_err_r;
    logic             write_s, last_word_s;

    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign core_reset   = core_reset_r;
    assign load_done    = load_done_r;
    assign frame_err    = frame_err_r;
    assign words_loaded = words_loaded_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign half_hit_s    = (cnt_r == HALF_CNT);
    assign full_hit_s    = (cnt_r == FULL_CNT);
    assign stop_sample_s = (rx_state_r == RX_STOP) && full_hit_s;
    assign frame_set_s   = stop_sample_s && !rx_sync_r;

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_next_s;
        end
    end

    // Receiver next-state logic
    always_comb begin
        rx_next_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) rx_next_s = RX_START;
                else            rx_next_s = RX_IDLE;
            end
            RX_START: begin
                // A high line at mid start bit is a glitch, not a frame
                if (half_hit_s) rx_next_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else            rx_next_s = RX_START;
            end
            RX_DATA: begin
                if (full_hit_s && bit_idx_r == 3'd7) rx_next_s = RX_STOP;
                else                                 rx_next_s = RX_DATA;
            end
            RX_STOP: begin
                if (full_hit_s) rx_next_s = RX_IDLE;
                else            rx_next_s = RX_STOP;
            end
            default: rx_next_s = RX_IDLE;
        endcase
    end

    // Receiver bit timing, shift register and byte hand-off
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            rx_byte_r    <= 8'd0;
            byte_valid_r <= 1'b0;
        end else begin
            byte_valid_r <= stop_sample_s && rx_sync_r;
            if (stop_sample_s && rx_sync_r) rx_byte_r <= shift_r;
            if (rx_state_r == RX_IDLE || (rx_state_r == RX_START && half_hit_s) || full_hit_s)
                cnt_r <= '0;
            else
                cnt_r <= cnt_r + 1'b1;
            if (rx_state_r == RX_DATA) begin
                if (full_hit_s) begin
                    shift_r   <= {rx_sync_r, shift_r[7:1]};
                    bit_idx_r <= bit_idx_r + 3'd1;
                end
            end else begin
                bit_idx_r <= 3'd0;
            end
        end
    end

    assign last_word_s = (words_loaded_r + 6'd1 == n_r);
    assign write_s     = (ld_state_r == L_DATA) && byte_valid_r && (byte_idx_r == 2'd3) && !load_req;

    // Loader state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_r <= L_COUNT;
        end else begin
            ld_state_r <= ld_next_s;
        end
    end

    // Loader next-state logic; load_req overrides everything, including a coincident byte
    always_comb begin
        ld_next_s = ld_state_r;
        if (load_req) begin
            ld_next_s = L_COUNT;
        end else begin
            case (ld_state_r)
                L_COUNT: begin
                    if (byte_valid_r) ld_next_s = L_DATA;
                    else              ld_next_s = L_COUNT;
                end
                L_DATA: begin
                    if (write_s && last_word_s) ld_next_s = L_DONE;
                    else                        ld_next_s = L_DATA;
                end
                L_DONE:  ld_next_s = L_DONE;
                default: ld_next_s = L_COUNT;
            endcase
        end
    end

    // Loader datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            n_r            <= 6'd0;
            byte_idx_r     <= 2'd0;
            word_idx_r     <= 5'd0;
            word_r         <= 32'd0;
            words_loaded_r <= 6'd0;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= 5'd0;
            imem_wdata_r   <= 32'd0;
            core_reset_r   <= 1'b1;
            load_done_r    <= 1'b0;
        end else if (load_req) begin
            byte_idx_r     <= 2'd0;
            word_idx_r     <= 5'd0;
            word_r         <= 32'd0;
            words_loaded_r <= 6'd0;
            imem_we_r      <= 1'b0;
            core_reset_r   <= 1'b1;
            load_done_r    <= 1'b0;
        end else begin
            imem_we_r <= write_s;
            case (ld_state_r)
                L_COUNT: begin
                    if (byte_valid_r) begin
                        n_r <= (rx_byte_r == 8'd0 || rx_byte_r > 8'(WORD_COUNT)) ?
                               6'(WORD_COUNT) : rx_byte_r[5:0];
                        byte_idx_r <= 2'd0;
                        word_idx_r <= 5'd0;
                    end
                end
                L_DATA: begin
                    if (byte_valid_r) begin
                        word_r[{byte_idx_r, 3'b000} +: 8] <= rx_byte_r;
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end
                    if (write_s) begin
                        imem_addr_r    <= word_idx_r;
                        imem_wdata_r   <= {rx_byte_r, word_r[23:0]};
                        words_loaded_r <= words_loaded_r + 6'd1;
                        if (word_idx_r != 5'(WORD_COUNT - 1)) word_idx_r <= word_idx_r + 5'd1;
                    end
                end
                L_DONE: begin
                    core_reset_r <= 1'b0;
                    load_done_r  <= 1'b1;
                end
                default: begin
                    core_reset_r <= 1'b1;
                    load_done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky framing error, cleared only by reset or a new load
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_r <= 1'b0;
        end else if (load_req) begin
            frame_err_r <= 1'b0;
        end else if (frame_set_s) begin
            frame_err_r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a fast UART (4 clocks per bit).
module tb_uart_program_loader;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset, uart_rx, load_req;
    logic        imem_we, core_reset, load_done, frame_err;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [5:0]  words_loaded;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int cr_fall_cyc = -1;
    logic prev_cr = 1'b1;
    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    uart_program_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(32)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .load_req(load_req),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .load_done(load_done), .frame_err(frame_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every write and the cycle in which core_reset falls
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (prev_cr === 1'b1 && core_reset === 1'b0) cr_fall_cyc = cyc;
        prev_cr = core_reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load_req();
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_we"},    {31'd0, imem_we},    32'd0);
        check({pfx, "_addr"},  {27'd0, imem_addr},  32'd0);
        check({pfx, "_wdata"}, imem_wdata,          32'd0);
        check({pfx, "_crst"},  {31'd0, core_reset}, 32'd1);
        check({pfx, "_done"},  {31'd0, load_done},  32'd0);
        check({pfx, "_ferr"},  {31'd0, frame_err},  32'd0);
        check({pfx, "_words"}, {26'd0, words_loaded}, 32'd0);
    endtask

    task automatic clamp_load(input logic [7:0] n, input string tag);
        logic [31:0] exp;
        clear_log();
        pulse_load_req();
        send_byte(n, 1'b1);
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b1);
        settle();
        check({tag, "_nwr"}, wr_addr.size(), 32'd32);
        for (int k = 0; k < 32; k++) begin
            exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            if (k < wr_addr.size()) begin
                check({tag, "_addr"}, {27'd0, wr_addr[k]}, 32'(k));
                check({tag, "_data"}, wr_data[k], exp);
            end
        end
        check({tag, "_done"},  {31'd0, load_done},    32'd1);
        check({tag, "_words"}, {26'd0, words_loaded}, 32'd32);
    endtask

    initial begin
        reset = 1'b1; uart_rx = 1'b1; load_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic load of two words
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        settle();
        check("basic_mid_crst",  {31'd0, core_reset},   32'd1);
        check("basic_mid_words", {26'd0, words_loaded}, 32'd1);
        send_byte(8'h00, 1'b1);
        settle();
        check("basic_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("basic_addr0", {27'd0, wr_addr[0]}, 32'd0);
            check("basic_data0", wr_data[0], 32'h0050_0013);
            check("basic_addr1", {27'd0, wr_addr[1]}, 32'd1);
            check("basic_data1", wr_data[1], 32'h0010_0093);
        end
        check("basic_crst",   {31'd0, core_reset},   32'd0);
        check("basic_done",   {31'd0, load_done},    32'd1);
        check("basic_words",  {26'd0, words_loaded}, 32'd2);
        check("basic_fall",   32'(cr_fall_cyc), 32'(last_we_cyc + 1));
        check("basic_hold_a", {27'd0, imem_addr}, 32'd1);
        check("basic_hold_d", imem_wdata, 32'h0010_0093);

        // Start-bit glitch while idle
        clear_log();
        uart_rx = 1'b0; @(posedge clk); #1; uart_rx = 1'b1;
        settle();
        check("glitch_nwr",  wr_addr.size(), 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check("glitch_done", {31'd0, load_done}, 32'd1);

        // load_req after a completed load
        clear_log();
        pulse_load_req();
        @(negedge clk);
        check("lreq_crst",  {31'd0, core_reset},   32'd1);
        check("lreq_done",  {31'd0, load_done},    32'd0);
        check("lreq_words", {26'd0, words_loaded}, 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        settle();
        check("lreq_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("lreq_addr", {27'd0, wr_addr[0]}, 32'd0);
            check("lreq_data", wr_data[0], 32'hEFBE_ADDE);
        end
        check("lreq_done2", {31'd0, load_done}, 32'd1);

        // Count clamp: zero and oversized counts both load 32 words
        clamp_load(8'd0, "clamp0");
        clamp_load(8'd40, "clamp40");
        clear_log();
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        settle();
        check("done_ignore_nwr", wr_addr.size(), 32'd0);

        // Framing error: bad byte is dropped, error stays sticky
        clear_log();
        pulse_load_req();
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        uart_rx = 1'b1;
        repeat (16) @(posedge clk); #1;
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_nowr", wr_addr.size(), 32'd0);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        settle();
        check("ferr_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) check("ferr_data", wr_data[0], 32'h5544_3311);
        check("ferr_done",   {31'd0, load_done}, 32'd1);
        check("ferr_sticky", {31'd0, frame_err}, 32'd1);

        // Reset in the middle of a load
        clear_log();
        pulse_load_req();
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid");
        @(posedge clk); #1;
        reset = 1'b0;
        settle();
        check("mid_nowr", wr_addr.size(), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        settle();
        check("mid_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("mid_addr", {27'd0, wr_addr[0]}, 32'd0);
            check("mid_data", wr_data[0], 32'h1234_5678);
        end
        check("mid_done", {31'd0, load_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time loader upstream of the single-cycle RV32I core's instruction memory. Receives a program over a UART serial line (8N1), assembles little-endian 32-bit words and drives the instruction-memory write port. Holds the core in reset until the load completes, then releases it so execution starts from PC 0 with the new image.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- WORD_COUNT, default 32: instruction-memory depth in words (7-bit byte address → 32 words).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- uart_rx  in  1  asynchronous serial input; idle high.
- load_req  in  1  one-cycle pulse: abort any load in progress and start a new one.
- imem_we  out  1  instruction-memory write strobe; one-cycle pulse per word.
- imem_addr  out  5  word index being written (byte address = imem_addr×4).
- imem_wdata  out  32  assembled instruction word.
- core_reset  out  1  drives the core's reset; high while loading.
- load_done  out  1  high once all words are written; stays high until reset or load_req.
- frame_err  out  1  sticky; set on any stop-bit error; cleared only by reset or load_req.
- words_loaded  out  6  count of words written in the current load.

## Operation
- uart_rx passes through a 2-flop synchronizer; both flops reset to 1.
- Receiver FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - **RX_IDLE:** a synchronized low moves to RX_START.
  - **RX_START:** wait CLKS_PER_BIT/2 cycles, then sample. If the sample is high, treat it as a glitch and return to RX_IDLE. If low, go to RX_DATA.
  - **RX_DATA:** sample 8 bits LSB first, one every CLKS_PER_BIT cycles.
  - **RX_STOP:** sample once, CLKS_PER_BIT cycles after the last data bit. If high, pulse an internal byte_valid with the byte. If low, set frame_err, discard the byte and emit no byte_valid. Return to RX_IDLE either way.
- Loader FSM: L_COUNT → L_DATA → L_DONE.
  - **L_COUNT:** the first valid byte is N. If N = 0 or N > WORD_COUNT, use N = WORD_COUNT. Clear byte_idx and word_idx, then go to L_DATA.
  - **L_DATA:** each valid byte is placed at word[8×byte_idx +: 8], with byte_idx running 0..3. On byte_idx = 3, pulse imem_we with imem_addr = word_idx and imem_wdata = the full word, then increment word_idx and words_loaded. After the Nth write, go to L_DONE.
  - **L_DONE:** core_reset = 0 and load_done = 1. Received bytes are ignored; frame_err still updates.
- load_req in any loader state:
  - loader FSM → L_COUNT; core_reset = 1; load_done = 0; words_loaded = 0.
  - partial word and byte_idx are discarded; frame_err is cleared.
  - the receiver is not reset, so a byte already in flight completes and is taken as the count byte.
- Words beyond N are never written. Memory contents above N−1 are left untouched.
- word_idx never exceeds WORD_COUNT−1, so there is no address wrap.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, load_done 0, frame_err 0, words_loaded 0. Both FSMs return to their idle/count states.
- Reset asserted mid-byte or mid-load aborts immediately. Nothing is written after reset.
- byte_valid occurs 1 cycle after the stop-bit sample.
- The stop-bit sample falls nominally (9.5×CLKS_PER_BIT + 2) cycles after the uart_rx falling edge; the +2 is synchronizer delay.
- imem_we is high for exactly 1 cycle, in the cycle after the 4th byte_valid of a word.
- imem_addr, imem_wdata and words_loaded are valid in that same cycle.
- imem_addr and imem_wdata hold their values after the write.
- core_reset falls and load_done rises in the cycle after the last imem_we; they change together.
- load_req coincident with byte_valid: load_req wins and the byte is dropped.
- load_req coincident with reset: reset wins.
- Back-to-back bytes, where the next start bit immediately follows the stop bit, must be received without loss.

## Test plan
The bench uses CLKS_PER_BIT = 4.
- **Basic load:** send N = 2, then 13 00 50 00, 93 00 10 00. Expect imem_we at addr 0 with 0x00500013, then at addr 1 with 0x00100093. Then core_reset 1→0, load_done = 1, words_loaded = 2.
- **Count clamp:** send N = 0, then 128 bytes. Expect 32 writes at addresses 0..31 and load_done = 1. Send N = 40 → same behaviour (clamped to 32).
- **Framing error:** send N = 1 with the second data byte's stop bit forced low. Expect frame_err = 1 and that byte discarded. Four further good bytes then complete the word, and load_done = 1 with frame_err still 1.
- **Start-bit glitch:** drive uart_rx low for 1 cycle in RX_IDLE. Expect no byte_valid, no write and frame_err = 0.
- **load_req after done:** complete a load, pulse load_req, then send N = 1 and DE AD BE EF. Expect core_reset high immediately and words_loaded = 0. Then one write at addr 0 with 0xEFBEADDE, followed by load_done = 1.
- **Reset mid-load:** assert reset after 2 data bytes. Expect all outputs at their reset values and no imem_we. A fresh load then proceeds normally from address 0.
